np_matrix_mult_acc: RTL and testbench

Multiply-accumulate datapath for the fully connected (FFN) stage. It consumes the feature-map word stream produced while the matrix-multiply controller sweeps its address and RAM-select counters. Each feature-map value is multiplied by one weight per output neuron, and the products are summed over the whole sweep. The finished neuron sums are then scaled, saturated and handed downstream through a valid/ready handshake.

---
 rtl/np_matrix_mult_acc.sv | 184 ++++++++++++++++++
 tb/tb_np_matrix_mult_acc.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/np_matrix_mult_acc.sv
// FFN multiply-accumulate: NUM_NEURONS parallel MACs over one sweep, then shift+saturate; result 2 cycles after last beat.
// One beat/cycle while accumulating (in_ready only in ACCUM); result held in HOLD until out_ready, upstream stalled meanwhile.
module np_matrix_mult_acc #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_NEURONS = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 8
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic                              in_last,
    input  logic [DATA_WIDTH-1:0]             fm_data,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] weights,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_NEURONS*OUT_WIDTH-1:0]  out_data,
    output logic                              busy,
    output logic                              overflow
);

    localparam int PW = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t state;

    logic signed [PW-1:0]        prod_q [NUM_NEURONS];
    logic                        s1_vld;
    logic                        s1_last;
    logic signed [ACC_WIDTH-1:0] acc_q  [NUM_NEURONS];

    logic signed [PW-1:0]        prod_d   [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] prod_add [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] sum      [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0] shifted  [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]      ovf_vec;
    logic [NUM_NEURONS*OUT_WIDTH-1:0] res_d;
    logic                        accept;

    assign accept = in_valid & in_ready;

    // Operands are sign-extended to product width so the multiply is exact in PW bits.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            prod_d[n] = $signed({{DATA_WIDTH{fm_data[DATA_WIDTH-1]}}, fm_data})
                      * $signed({{DATA_WIDTH{weights[n*DATA_WIDTH+DATA_WIDTH-1]}},
                                 weights[n*DATA_WIDTH +: DATA_WIDTH]});
        end
    end

    always_comb begin
        res_d   = '0;
        ovf_vec = '0;
        for (int n = 0; n < NUM_NEURONS; n++) begin
            prod_add[n] = s1_vld ? {{(ACC_WIDTH-PW){prod_q[n][PW-1]}}, prod_q[n]}
                                 : '0;
            sum[n]      = acc_q[n] + prod_add[n];
            ovf_vec[n]  = (acc_q[n][ACC_WIDTH-1] == prod_add[n][ACC_WIDTH-1]) &&
                          (sum[n][ACC_WIDTH-1] != acc_q[n][ACC_WIDTH-1]);
            shifted[n]  = sum[n] >>> SHIFT;
            if (shifted[n] > SAT_MAX) begin
                res_d[n*OUT_WIDTH +: OUT_WIDTH] = SAT_MAX[OUT_WIDTH-1:0];
            end else if (shifted[n] < SAT_MIN) begin
                res_d[n*OUT_WIDTH +: OUT_WIDTH] = SAT_MIN[OUT_WIDTH-1:0];
            end else begin
                res_d[n*OUT_WIDTH +: OUT_WIDTH] = shifted[n][OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
            out_data  <= '0;
            s1_vld    <= 1'b0;
            s1_last   <= 1'b0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                prod_q[n] <= '0;
                acc_q[n]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        s1_vld   <= 1'b0;
                        s1_last  <= 1'b0;
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            prod_q[n] <= '0;
                            acc_q[n]  <= '0;
                        end
                    end
                end

                ACCUM: begin
                    if (start) begin
                        // Restart: drop everything in flight, including a beat offered this cycle.
                        overflow <= 1'b0;
                        s1_vld   <= 1'b0;
                        s1_last  <= 1'b0;
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            prod_q[n] <= '0;
                            acc_q[n]  <= '0;
                        end
                    end else begin
                        if (s1_vld) begin
                            for (int n = 0; n < NUM_NEURONS; n++) begin
                                acc_q[n] <= sum[n];
                            end
                            if (|ovf_vec) begin
                                overflow <= 1'b1;
                            end
                        end
                        if (accept) begin
                            for (int n = 0; n < NUM_NEURONS; n++) begin
                                prod_q[n] <= prod_d[n];
                            end
                            s1_vld  <= 1'b1;
                            s1_last <= in_last;
                            if (in_last) begin
                                state    <= DRAIN;
                                in_ready <= 1'b0;
                            end
                        end else begin
                            s1_vld <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    // Final product folds in combinationally on its way to the output register.
                    out_data  <= res_d;
                    out_valid <= 1'b1;
                    if (s1_vld && s1_last && (|ovf_vec)) begin
                        overflow <= 1'b1;
                    end
                    s1_vld  <= 1'b0;
                    s1_last <= 1'b0;
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        acc_q[n] <= '0;
                    end
                    state <= HOLD;
                end

                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end

                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_np_matrix_mult_acc.sv
// Directed bench: two instances (SHIFT=0 and SHIFT=8) share stimulus; expected values are hand-computed constants.
module tb_np_matrix_mult_acc;

    localparam int DW = 8;
    localparam int NN = 4;
    localparam int AW = 24;
    localparam int OW = 16;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic           start;
    logic           in_valid;
    logic           in_last;
    logic           out_ready;
    logic [DW-1:0]  fm_data;
    logic [NN*DW-1:0] weights;

    logic           in_ready0, in_ready8;
    logic           out_valid0, out_valid8;
    logic           busy0, busy8;
    logic           ovf0, ovf8;
    logic [NN*OW-1:0] out0, out8;

    int n_tests = 0;
    int n_fail  = 0;

    np_matrix_mult_acc #(.DATA_WIDTH(DW), .NUM_NEURONS(NN), .ACC_WIDTH(AW),
                         .OUT_WIDTH(OW), .SHIFT(0)) dut0 (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready0), .in_last(in_last),
        .fm_data(fm_data), .weights(weights),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out0),
        .busy(busy0), .overflow(ovf0)
    );

    np_matrix_mult_acc #(.DATA_WIDTH(DW), .NUM_NEURONS(NN), .ACC_WIDTH(AW),
                         .OUT_WIDTH(OW), .SHIFT(8)) dut8 (
        .clock(clock), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last),
        .fm_data(fm_data), .weights(weights),
        .out_valid(out_valid8), .out_ready(out_ready), .out_data(out8),
        .busy(busy8), .overflow(ovf8)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] w4(input int a, input int b, input int c, input int d);
        return {8'(d), 8'(c), 8'(b), 8'(a)};
    endfunction

    function automatic logic [63:0] o4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic beat(input int fm, input logic [31:0] w, input logic last);
        in_valid = 1'b1;
        fm_data  = 8'(fm);
        weights  = w;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called right after the edge that accepted the last beat.
    task automatic finish_pass(input string tag, input logic [63:0] exp0, input logic [63:0] exp8);
        check({tag, "_drain_vld"}, 64'(out_valid0), 64'd0);
        step();
        check({tag, "_vld0"}, 64'(out_valid0), 64'd1);
        check({tag, "_vld8"}, 64'(out_valid8), 64'd1);
        check({tag, "_rdy"},  64'(in_ready0), 64'd0);
        check({tag, "_out0"}, out0, exp0);
        check({tag, "_out8"}, out8, exp8);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_vld_fall"}, 64'(out_valid0), 64'd0);
        check({tag, "_idle"},     64'(busy0), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        fm_data   = '0;
        weights   = '0;
        #12;
        check("rst_rdy",  64'(in_ready0), 64'd0);
        check("rst_vld",  64'(out_valid0), 64'd0);
        check("rst_busy", 64'(busy0), 64'd0);
        check("rst_ovf",  64'(ovf0), 64'd0);
        check("rst_out",  out0, 64'd0);
        reset = 1'b0;
        step();

        // Basic pass: 2*1 + 3*2 + (-1)*4 = 4
        pulse_start();
        check("basic_rdy",  64'(in_ready0), 64'd1);
        check("basic_busy", 64'(busy0), 64'd1);
        beat(2,  w4(1, 0, 0, 0), 1'b0);
        beat(3,  w4(2, 0, 0, 0), 1'b0);
        beat(-1, w4(4, 0, 0, 0), 1'b1);
        finish_pass("basic", o4(4, 0, 0, 0), o4(0, 0, 0, 0));
        check("basic_ovf", 64'(ovf0), 64'd0);
        handshake("basic");

        // Reset in the middle of ACCUM with in_valid high
        pulse_start();
        in_valid = 1'b1;
        fm_data  = 8'd5;
        weights  = w4(5, 5, 5, 5);
        step();
        step();
        #2;
        reset = 1'b1;
        #1;
        check("mrst_rdy",  64'(in_ready0), 64'd0);
        check("mrst_busy", 64'(busy0), 64'd0);
        check("mrst_vld",  64'(out_valid0), 64'd0);
        check("mrst_out",  out0, 64'd0);
        check("mrst_ovf",  64'(ovf0), 64'd0);
        #3;
        reset = 1'b0;
        step();
        step();
        check("mrst_stay_idle", 64'(busy0), 64'd0);
        check("mrst_stay_rdy",  64'(in_ready0), 64'd0);
        in_valid = 1'b0;

        // Saturation: 255 x 127*127 on n0, 255 x 127*(-128) on n1
        pulse_start();
        for (int i = 0; i < 255; i++) begin
            beat(127, w4(127, -128, 0, 0), (i == 254));
        end
        finish_pass("sat", o4(32767, -32768, 0, 0), o4(16065, -16193, 0, 0));
        check("sat_ovf", 64'(ovf0), 64'd0);
        handshake("sat");

        // Shift/floor, single-beat passes
        pulse_start();
        beat(-1, w4(1, 0, 0, 0), 1'b1);
        finish_pass("shneg", o4(-1, 0, 0, 0), o4(-1, 0, 0, 0));
        handshake("shneg");
        pulse_start();
        beat(127, w4(127, 0, 0, 0), 1'b1);
        finish_pass("shpos", o4(16129, 0, 0, 0), o4(63, 0, 0, 0));
        handshake("shpos");

        // Backpressure in HOLD with start/in_valid pulsed
        pulse_start();
        beat(3, w4(7, 0, 0, -2), 1'b1);
        finish_pass("bp", o4(21, 0, 0, -6), o4(0, 0, 0, -1));
        for (int i = 0; i < 5; i++) begin
            start    = (i == 1 || i == 3);
            in_valid = 1'b1;
            fm_data  = 8'd9;
            weights  = w4(9, 9, 9, 9);
            step();
            check("bp_hold_out", out0, o4(21, 0, 0, -6));
            check("bp_hold_vld", 64'(out_valid0), 64'd1);
            check("bp_hold_rdy", 64'(in_ready0), 64'd0);
        end
        start    = 1'b0;
        in_valid = 1'b0;
        handshake("bp");
        step();
        check("bp_retain", out0, o4(21, 0, 0, -6));

        // Overflow: 520 x (-128)*(-128) wraps past 2^23
        pulse_start();
        for (int i = 0; i < 520; i++) begin
            beat(-128, w4(-128, 0, 0, 0), (i == 519));
        end
        finish_pass("ovf", o4(-32768, 0, 0, 0), o4(-32256, 0, 0, 0));
        check("ovf_flag", 64'(ovf0), 64'd1);
        handshake("ovf");

        // Restart after 10 beats; offered beat on the restart cycle is dropped
        pulse_start();
        check("rs_ovf_clr", 64'(ovf0), 64'd0);
        for (int i = 0; i < 10; i++) begin
            beat(5, w4(3, 1, 0, 0), 1'b0);
        end
        start    = 1'b1;
        in_valid = 1'b1;
        fm_data  = 8'd100;
        weights  = w4(100, 100, 0, 0);
        step();
        start    = 1'b0;
        in_valid = 1'b0;
        check("rs_busy", 64'(busy0), 64'd1);
        beat(2, w4(3, 0, 0, 0), 1'b0);
        beat(4, w4(5, 0, 0, 0), 1'b1);
        finish_pass("rs", o4(26, 0, 0, 0), o4(0, 0, 0, 0));
        check("rs_ovf", 64'(ovf0), 64'd0);
        handshake("rs");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
